// File: rtl/augment_pkg.sv
// Shared types and defaults for the augmentation pipeline output stage.
//   writer_state_t   : state encoding of the pixel word writer FSM
//   IMAGE_PIXELS_DEF : default pixels per image (28x28)
//   SLOT_STRIDE_DEF  : default byte distance between the two image slots
//   lane_mask()      : byte-enable mask covering the lowest n lanes
package augment_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } writer_state_t;

  localparam int          IMAGE_PIXELS_DEF = 784;
  localparam logic [31:0] SLOT_STRIDE_DEF  = 32'h0000_0400;

  // (1 << n) - 1 for n in 0..3: 0, 1, 3, 7.
  function automatic logic [3:0] lane_mask(input logic [1:0] n);
    return (4'd1 << n) - 4'd1;
  endfunction

endpackage

// File: rtl/pixel_lane_packer.sv
// Packs 8-bit pixels into 32-bit words, lowest lane first.
//   clk, reset     : clock, synchronous active-high reset
//   clear_i        : discard any partially packed word
//   accept_i       : pixel_i is taken this cycle
//   pixel_i        : incoming pixel
//   word_ready_o   : the accepted pixel completes a word this cycle
//   full_word_o    : stored lanes merged with the pixel being accepted
//   partial_word_o : same, with lanes not yet filled forced to zero
//   partial_mask_o : byte enables for the filled lanes (0 when none)
module pixel_lane_packer
  import augment_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  pixel_i,
  output logic        word_ready_o,
  output logic [31:0] full_word_o,
  output logic [31:0] partial_word_o,
  output logic [3:0]  partial_mask_o
);

  logic [1:0]      lane_q;
  logic [3:0][7:0] lanes_q;
  logic [3:0][7:0] merged;
  logic [1:0]      lane_after;

  always_comb begin
    merged = lanes_q;
    if (accept_i) merged[lane_q] = pixel_i;
    // Two-bit wrap: completing lane 3 leaves no partial lanes behind.
    lane_after     = accept_i ? lane_q + 2'd1 : lane_q;
    word_ready_o   = accept_i && (lane_q == 2'd3);
    partial_mask_o = lane_mask(lane_after);
    full_word_o    = merged;
    for (int i = 0; i < 4; i++) begin
      partial_word_o[8*i +: 8] = partial_mask_o[i] ? merged[i] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i || word_ready_o) begin
      lane_q  <= 2'd0;
      lanes_q <= '0;
    end else if (accept_i) begin
      lanes_q[lane_q] <= pixel_i;
      lane_q          <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/pixel_word_writer.sv
// Packs an 8-bit pixel stream into 32-bit BRAM writes, ping-ponging
// complete images between two slots.
//   clk, reset         : clock, synchronous active-high reset
//   pixel, pixel_valid : upstream pixel stream, no backpressure
//   image_done         : upstream end-of-image pulse
//   bram_addr/data     : byte address and data of the BRAM write
//   write_enable       : byte enables, 4'h0 = no write
//   write_done         : one-cycle pulse when an image is committed
//   slot               : slot holding the last committed image
//   busy               : first accepted pixel until commit
//   overflow           : sticky, pixel dropped (FLUSH/DONE or image full)
//   dbg_state          : current FSM state for observation
// Interface: pixel_valid is a pure valid with no ready; a pixel is either
// accepted in the cycle it is valid or dropped and flagged as overflow.
// All outputs are registered; a write is registered on the same edge
// that accepts its last pixel or enters FLUSH, so FLUSH itself only
// waits one cycle before DONE.
module pixel_word_writer
  import augment_pkg::*;
#(
  parameter int          IMAGE_PIXELS = IMAGE_PIXELS_DEF,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] SLOT_STRIDE  = SLOT_STRIDE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    pixel,
  input  logic          pixel_valid,
  input  logic          image_done,
  output logic [31:0]   bram_addr,
  output logic [31:0]   bram_data,
  output logic [3:0]    write_enable,
  output logic          write_done,
  output logic          slot,
  output logic          busy,
  output logic          overflow,
  output writer_state_t dbg_state
);

  localparam int CNT_W  = $clog2(IMAGE_PIXELS + 1);
  localparam int WIDX_R = $clog2((IMAGE_PIXELS + 3) / 4);
  localparam int WIDX_W = (WIDX_R > 0) ? WIDX_R : 1;
  localparam logic [CNT_W-1:0] IMG_CNT = CNT_W'(IMAGE_PIXELS);

  writer_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_after;
  logic [WIDX_W-1:0] word_idx_q;
  logic              wr_slot_q;
  logic              accept, flush_go, issue_full, issue_partial, enter_done;
  logic [31:0]       full_word, partial_word, cur_addr;
  logic [3:0]        partial_mask;

  pixel_lane_packer u_packer (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (flush_go),
    .accept_i       (accept),
    .pixel_i        (pixel),
    .word_ready_o   (issue_full),
    .full_word_o    (full_word),
    .partial_word_o (partial_word),
    .partial_mask_o (partial_mask)
  );

  always_comb begin
    accept = pixel_valid && (state_q == ST_IDLE || state_q == ST_PACK)
             && (count_q != IMG_CNT);
    count_after = count_q + {{(CNT_W-1){1'b0}}, accept};
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (image_done || count_after == IMG_CNT) ? ST_FLUSH : ST_PACK;
        end else if (image_done) begin
          state_d = ST_DONE;
        end
      end
      ST_PACK:  if (image_done || count_after == IMG_CNT) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // FLUSH is only ever entered for one cycle, so this marks the entry edge.
    flush_go      = (state_d == ST_FLUSH);
    enter_done    = (state_d == ST_DONE);
    issue_partial = flush_go && !issue_full && (partial_mask != 4'h0);
    cur_addr      = BASE_ADDR + (wr_slot_q ? SLOT_STRIDE : 32'd0)
                    + 32'({word_idx_q, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      wr_slot_q    <= 1'b0;
      bram_addr    <= '0;
      bram_data    <= '0;
      write_enable <= 4'h0;
      write_done   <= 1'b0;
      slot         <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_done   <= enter_done;
      write_enable <= 4'h0;
      if (pixel_valid && !accept) overflow <= 1'b1;

      if (issue_full || issue_partial) begin
        bram_addr    <= cur_addr;
        bram_data    <= issue_full ? full_word : partial_word;
        write_enable <= issue_full ? 4'hF : partial_mask;
      end

      if (enter_done) begin
        count_q    <= '0;
        word_idx_q <= '0;
        busy       <= 1'b0;
        // An empty image reaches DONE straight from IDLE with count 0.
        if (count_q != '0) begin
          slot      <= wr_slot_q;
          wr_slot_q <= ~wr_slot_q;
        end
      end else begin
        count_q <= count_after;
        if (issue_full || issue_partial) word_idx_q <= word_idx_q + 1'b1;
        if (accept) busy <= 1'b1;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_word_writer.sv
module tb_pixel_word_writer;
  import augment_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    pixel;
  logic          pixel_valid;
  logic          image_done;
  logic [31:0]   bram_addr;
  logic [31:0]   bram_data;
  logic [3:0]    write_enable;
  logic          write_done;
  logic          slot;
  logic          busy;
  logic          overflow;
  writer_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Expected writes: {addr[31:0], data[31:0], we[3:0]}
  logic [67:0] exp_q[$];

  pixel_word_writer dut (
    .clk          (clk),
    .reset        (reset),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .image_done   (image_done),
    .bram_addr    (bram_addr),
    .bram_data    (bram_data),
    .write_enable (write_enable),
    .write_done   (write_done),
    .slot         (slot),
    .busy         (busy),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    pixel_valid = 1'b0;
    image_done = 1'b0;
    pixel = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pixel(input logic [7:0] v, input logic done);
    pixel = v;
    pixel_valid = 1'b1;
    image_done = done;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    image_done = 1'b0;
    pixel = 8'h00;
  endtask

  task automatic send_done();
    image_done = 1'b1;
    @(posedge clk); #1;
    image_done = 1'b0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    exp_q.push_back({a, d, we});
  endtask

  // Called right after the edge that took the last pixel (or image_done):
  // nothing in the next cycle, write_done the cycle after.
  task automatic wait_done_check(input string tag, input logic exp_slot);
    @(negedge clk);
    check_eq({tag, "_done_early"}, write_done, 1'b0);
    @(negedge clk);
    check_eq({tag, "_done"}, write_done, 1'b1);
    check_eq({tag, "_slot"}, slot, exp_slot);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_addr"}, bram_addr, 32'h0);
    check_eq({tag, "_data"}, bram_data, 32'h0);
    check_eq({tag, "_we"}, write_enable, 4'h0);
    check_eq({tag, "_wdone"}, write_done, 1'b0);
    check_eq({tag, "_slot"}, slot, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_ovf"}, overflow, 1'b0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (write_done) done_cnt++;
    if (write_enable != 4'h0) begin
      if (exp_q.size() == 0) begin
        check_eq("write_unexp", write_enable, 4'h0);
      end else begin
        check_eq("write", {bram_addr, bram_data, write_enable}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    pixel = 8'h00;
    pixel_valid = 1'b0;
    image_done = 1'b0;
    idle(2);
    do_reset();
    @(negedge clk);
    check_zero_outputs("rst");

    // Two full words, no commit until image_done.
    push_write(32'h000, 32'h04030201, 4'hF);
    push_write(32'h004, 32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) send_pixel(8'(i), 1'b0);
    idle(3);
    check_eq("eight_no_done", done_cnt, 0);
    check_eq("eight_busy", busy, 1'b1);
    send_done();
    wait_done_check("eight", 1'b0);

    // Full image auto-completes without image_done.
    do_reset();
    for (int w = 0; w < 196; w++) begin
      push_write(32'(4 * w),
                 {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}, 4'hF);
    end
    for (int i = 0; i < 784; i++) send_pixel(8'(i), 1'b0);
    wait_done_check("full", 1'b0);
    // Second image lands in slot 1; image_done with a lane-3 pixel.
    push_write(32'h400, 32'h04030201, 4'hF);
    push_write(32'h404, 32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) send_pixel(8'(i), i == 8);
    wait_done_check("second", 1'b1);

    // Partial word flush.
    do_reset();
    push_write(32'h000, 32'hA3A2A1A0, 4'hF);
    push_write(32'h004, 32'h0000A5A4, 4'h3);
    for (int i = 0; i < 6; i++) send_pixel(8'hA0 + 8'(i), i == 5);
    wait_done_check("partial", 1'b0);

    // Empty image: pulse only, slots untouched.
    done_cnt = 0;
    send_done();
    @(negedge clk);
    check_eq("empty_done", write_done, 1'b1);
    check_eq("empty_slot", slot, 1'b0);
    check_eq("empty_qempty", exp_q.size(), 0);
    @(posedge clk); #1;
    push_write(32'h400, 32'h34333231, 4'hF);
    for (int i = 0; i < 4; i++) send_pixel(8'h31 + 8'(i), i == 3);
    wait_done_check("after_empty", 1'b1);
    check_eq("empty_done_cnt", done_cnt, 2);

    // Pixel 785 dropped, overflow sticky.
    do_reset();
    @(negedge clk);
    check_eq("ovf_pre", overflow, 1'b0);
    for (int w = 0; w < 196; w++) begin
      push_write(32'(4 * w),
                 {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}, 4'hF);
    end
    for (int i = 0; i < 785; i++) send_pixel(8'(i), 1'b0);
    @(negedge clk);
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("ovf_done", write_done, 1'b1);
    check_eq("ovf_qempty", exp_q.size(), 0);
    idle(2);
    send_done();
    @(negedge clk);
    check_eq("ovf_empty_done", write_done, 1'b1);
    check_eq("ovf_empty_slot", slot, 1'b0);
    @(posedge clk); #1;
    push_write(32'h400, 32'h44434241, 4'hF);
    for (int i = 0; i < 4; i++) send_pixel(8'h41 + 8'(i), i == 3);
    wait_done_check("ovf_next", 1'b1);
    check_eq("ovf_sticky", overflow, 1'b1);

    // Reset mid-image discards the partial word.
    do_reset();
    for (int i = 0; i < 3; i++) send_pixel(8'h51 + 8'(i), 1'b0);
    @(negedge clk);
    check_eq("mid_busy", busy, 1'b1);
    do_reset();
    @(negedge clk);
    check_zero_outputs("mid_rst");
    push_write(32'h000, 32'h14131211, 4'hF);
    for (int i = 0; i < 4; i++) send_pixel(8'h11 + 8'(i), i == 3);
    wait_done_check("mid_next", 1'b0);

    idle(2);
    check_eq("final_qempty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_word_writer.md
# pixel_word_writer

Downstream stage of the rotation engine in the augmentation pipeline. Accepts the 8-bit pixel stream (`pixel`/`pixel_valid`) plus the end-of-image pulse and packs four consecutive pixels into one 32-bit word. Writes each word into the output BRAM port (address, data, 4-bit byte write enable). Ping-pongs between two image slots so software can read one image while the next is written.

## Interface
- `IMAGE_PIXELS`, 784: pixels per image (28x28); auto-complete threshold.
- `BASE_ADDR`, 32'h0000_0000: byte address of slot 0; word aligned.
- `SLOT_STRIDE`, 32'h0000_0400: byte offset of slot 1 from slot 0; must be at least 4*ceil(IMAGE_PIXELS/4).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `pixel`  in  8  upstream pixel.
- `pixel_valid`  in  1  `pixel` valid this cycle; no backpressure.
- `image_done`  in  1  upstream end-of-image pulse.
- `bram_addr`  out  32  byte address of output BRAM word.
- `bram_data`  out  32  write data; pixel n of a word sits in bits [8n+7:8n].
- `write_enable`  out  4  byte enables; 4'h0 means no write.
- `write_done`  out  1  one-cycle pulse when an image is committed.
- `slot`  out  1  slot holding the last committed image.
- `busy`  out  1  high from first accepted pixel until `write_done`.
- `overflow`  out  1  sticky; pixel arrived after `IMAGE_PIXELS` reached in the current image.

## Operation
- FSM states: IDLE, PACK, FLUSH, DONE.
- IDLE -> PACK on the first `pixel_valid`.
- IDLE -> DONE on `image_done` with no pixels (empty image).
- PACK -> FLUSH on `image_done`, or when the pixel count reaches `IMAGE_PIXELS`.
- FLUSH -> DONE always.
- DONE -> IDLE always.
- Lane counter 0..3; pixel stored in lane `lane`, then lane increments. At lane 3 the word is issued and the lane wraps to 0.
- Word index increments per issued word.
- Address = `BASE_ADDR` + (`wr_slot` ? `SLOT_STRIDE` : 0) + 4*`word_idx`.
- FLUSH with lane=n>0 issues a partial word: `write_enable` = (1<<n)-1, unused bytes zero. With lane=0, FLUSH issues no write.
- DONE: `write_done`=1 for one cycle. If at least one pixel was written, `slot` := `wr_slot`, then `wr_slot` toggles. Counters clear.
- Empty image: `write_done` pulses; `slot` and `wr_slot` unchanged.
- `pixel_valid` and `image_done` in the same cycle: pixel accepted first, then FLUSH.
- After auto-complete (count = `IMAGE_PIXELS`), a later `image_done` while IDLE starts an empty image; it does not write twice.
- `pixel_valid` in FLUSH or DONE, or when the count is already `IMAGE_PIXELS`: pixel dropped, `overflow` set.
- `overflow` clears only on `reset`.
- Pixel count width: $clog2(`IMAGE_PIXELS`+1). Word index width: $clog2(ceil(`IMAGE_PIXELS`/4)).

## Timing
- Reset values:
  - outputs: `bram_addr`=0, `bram_data`=0, `write_enable`=0, `write_done`=0, `slot`=0, `busy`=0, `overflow`=0.
  - internal: `wr_slot`=0, lane=0, count=0, state IDLE.
- All outputs are registered.
- Full word: 4th pixel valid in cycle k -> `write_enable`=4'hF in k+1; held exactly one cycle.
- Flush: `image_done` in cycle k -> partial write in k+1 (if any) -> `write_done` in k+2.
- Auto-complete: last pixel in cycle k (lane 3 for 784) -> word write in k+1, then `write_done` in k+2.
- Back-to-back pixels every cycle are sustained: one write every 4 cycles.
- `reset` mid-image: next cycle all outputs and counters return to reset values. Partial word discarded; no write issued.

## Structure
- Package `augment_pkg`:
  - state enum `writer_state_t`
  - default constants `IMAGE_PIXELS_DEF`=784, `SLOT_STRIDE_DEF`=32'h400
- Sub-module `pixel_lane_packer`: lane counter, 4x8 shift/lane register, word-ready and partial-mask outputs.
- Top holds the FSM, address generation and slot logic.

## Test plan
- Pixels 8'h01..8'h08 on consecutive cycles:
  - two writes, addr 0x000 data 0x04030201 we 4'hF, then addr 0x004 data 0x08070605;
  - no `write_done` until `image_done`.
- 784 pixels (value = index mod 256), no `image_done`:
  - 196 writes at 0x000..0x30C, `write_done` 2 cycles after the last pixel, `slot`=0.
  - A second image goes to 0x400.., and `slot`=1.
- 6 pixels 8'hA0..8'hA5, `image_done` with the 6th pixel:
  - write 0xA3A2A1A0 we 4'hF;
  - then addr 0x004 data 0x0000A5A4 we 4'h3;
  - then `write_done`.
- `image_done` with no pixels: `write_done` pulse, no write, `slot`/`wr_slot` unchanged.
- Pixel 785 sent before `image_done`: dropped, `overflow`=1 and stays set through the next image.
- `reset` asserted after 3 pixels:
  - no write;
  - the next image starts at addr 0x000 lane 0;
  - all outputs zero the cycle after reset.
